// File: rtl/clk_pkg.sv
// clk_pkg: shared constants for the 32.768 kHz reference divider
package clk_pkg;
  localparam int REFCLK_HZ = 32768;
  localparam int DEFAULT_CNT_WIDTH = 15;
  localparam int DEFAULT_NUM_TAPS = 4;
  localparam logic [31:0] DEFAULT_TAP_BITS = {8'd3, 8'd11, 8'd13, 8'd14};
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_LOST_TIMEOUT = 1023;
endpackage

// File: rtl/refclk_sync.sv
// refclk_sync: i_refclk synchronizer + history flop; ports i_clk, i_reset_n, i_refclk in, o_stb one-cycle rise pulse out
module refclk_sync
  import clk_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_refclk,
  output logic o_stb
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic hist_q, hist_d;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_refclk};
    hist_d = sync_q[SYNC_STAGES-1];
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end
  assign o_stb = sync_q[SYNC_STAGES-1] & ~hist_q;
endmodule

// File: rtl/refclk_divider.sv
// refclk_divider: counts synchronized refclk edges; ports i_clk, i_reset_n, i_refclk, i_clear, i_tap_en in; o_refclk_stb, o_tap_stb, o_count, o_refclk_lost out
module refclk_divider
  import clk_pkg::*;
#(
  parameter int                    CNT_WIDTH    = DEFAULT_CNT_WIDTH,
  parameter int                    NUM_TAPS     = DEFAULT_NUM_TAPS,
  parameter logic [8*NUM_TAPS-1:0] TAP_BITS     = DEFAULT_TAP_BITS,
  parameter int                    SYNC_STAGES  = DEFAULT_SYNC_STAGES,
  parameter int                    LOST_TIMEOUT = DEFAULT_LOST_TIMEOUT
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_refclk,
  input  logic                 i_clear,
  input  logic [NUM_TAPS-1:0]  i_tap_en,
  output logic                 o_refclk_stb,
  output logic [NUM_TAPS-1:0]  o_tap_stb,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_refclk_lost
);
  localparam logic [15:0] LOST_MAX = 16'(LOST_TIMEOUT);
  if (CNT_WIDTH < 2 || CNT_WIDTH > 24) begin : g_bad_cnt
    $error("CNT_WIDTH out of range 2..24");
  end
  if (NUM_TAPS < 1 || NUM_TAPS > 8) begin : g_bad_taps
    $error("NUM_TAPS out of range 1..8");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES out of range 2..4");
  end
  if (LOST_TIMEOUT < 1 || LOST_TIMEOUT > 65535) begin : g_bad_lost
    $error("LOST_TIMEOUT out of range 1..65535");
  end
  logic                 stb, inc;
  logic [NUM_TAPS-1:0]  tap_hit, tap_q, tap_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [15:0]          wd_q, wd_d;
  logic                 lost_q, lost_d;
  refclk_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_refclk (i_refclk),
    .o_stb    (stb)
  );
  // a tap fires when the low bits up to its index are all ones, i.e. the increment carries out of that bit
  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
    localparam int T = int'(TAP_BITS[8*i+:8]);
    if (T >= CNT_WIDTH) begin : g_bad
      $error("TAP_BITS index must be below CNT_WIDTH");
      assign tap_hit[i] = 1'b0;
    end else begin : g_ok
      assign tap_hit[i] = &count_q[T:0];
    end
  end
  always_comb begin
    inc     = stb & ~i_clear;
    count_d = i_clear ? '0 : inc ? count_q + 1'b1 : count_q;
    tap_d   = inc ? tap_hit & i_tap_en : '0;
    wd_d    = stb ? '0 : wd_q == LOST_MAX ? wd_q : wd_q + 1'b1;
    // looking at wd_d makes the flag appear in the same cycle the watchdog reaches its limit
    lost_d  = ~stb & (lost_q | (wd_d == LOST_MAX));
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      count_q <= '0;
      tap_q   <= '0;
      wd_q    <= '0;
      lost_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tap_q   <= tap_d;
      wd_q    <= wd_d;
      lost_q  <= lost_d;
    end
  end
  assign o_refclk_stb  = stb;
  assign o_tap_stb     = tap_q;
  assign o_count       = count_q;
  assign o_refclk_lost = lost_q;
endmodule
